osd_regaccess_demux: RTL

OSD_REGACCESS_DEMUX -- requirements
Module: osd_regaccess_demux

---
 rtl/osd_regaccess_demux.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/osd_regaccess_demux.sv
// Debug-interconnect demux: register-access packets (TYPE 2'b00) go to out_reg, all others to out_bypass.
// Build option OSD_REGACCESS_DEMUX_BYPASS_EN: when undefined, out_bypass is tied off and non-REG packets are dropped.
package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_regaccess_demux
  import dii_package::*;
(
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_flit,
  output logic    in_ready,
  output dii_flit out_reg,
  input  logic    out_reg_ready,
  output dii_flit out_bypass,
  input  logic    out_bypass_ready
);

  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    HDR2    = 3'd2,
    REPLAY0 = 3'd3,
    REPLAY1 = 3'd4,
    REPLAY2 = 3'd5,
    STREAM  = 3'd6,
    DROP    = 3'd7
  } state_t;

  // A short packet has already delivered its last flit, so without bypass there is nothing left to drop.
`ifdef OSD_REGACCESS_DEMUX_BYPASS_EN
  localparam state_t SHORT_EXIT = REPLAY0;
`else
  localparam state_t SHORT_EXIT = HDR0;
`endif

  state_t      state_r;
  logic [15:0] hdr0_r, hdr1_r, hdr2_r;
  logic        last0_r, last1_r, last2_r;
  logic        route_reg_r;
  logic        bypass_ready_s;
  logic        sel_ready_s;
  logic        accept_s;
  dii_flit     sel_flit_s;

`ifdef OSD_REGACCESS_DEMUX_BYPASS_EN
  assign bypass_ready_s = out_bypass_ready;
`else
  logic unused_bypass_ready_s;
  assign unused_bypass_ready_s = out_bypass_ready;
  assign bypass_ready_s        = 1'b0;
`endif

  assign sel_ready_s = route_reg_r ? out_reg_ready : bypass_ready_s;
  assign accept_s    = in_flit.valid && in_ready;

  // Selected-output flit and upstream ready, decoded from the current state.
  always_comb begin
    sel_flit_s = '0;
    in_ready   = 1'b0;
    if (rst) begin
      sel_flit_s = '0;
      in_ready   = 1'b0;
    end else begin
      case (state_r)
        HDR0, HDR1, HDR2, DROP: in_ready = 1'b1;
        REPLAY0: sel_flit_s = '{valid: 1'b1, last: last0_r, data: hdr0_r};
        REPLAY1: sel_flit_s = '{valid: 1'b1, last: last1_r, data: hdr1_r};
        REPLAY2: sel_flit_s = '{valid: 1'b1, last: last2_r, data: hdr2_r};
        STREAM: begin
          in_ready = sel_ready_s;
          if (in_flit.valid) begin
            sel_flit_s = in_flit;
          end else begin
            sel_flit_s = '0;
          end
        end
        default: begin
          sel_flit_s = '0;
          in_ready   = 1'b0;
        end
      endcase
    end
  end

  // Steer the selected flit; the other output stays all-zero.
  always_comb begin
    out_reg    = '0;
    out_bypass = '0;
    if (route_reg_r) begin
      out_reg = sel_flit_s;
    end else begin
`ifdef OSD_REGACCESS_DEMUX_BYPASS_EN
      out_bypass = sel_flit_s;
`else
      out_bypass = '0;
`endif
    end
  end

  // Header capture, replay sequencing and packet framing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= HDR0;
      hdr0_r      <= 16'h0000;
      hdr1_r      <= 16'h0000;
      hdr2_r      <= 16'h0000;
      last0_r     <= 1'b0;
      last1_r     <= 1'b0;
      last2_r     <= 1'b0;
      route_reg_r <= 1'b0;
    end else begin
      case (state_r)
        HDR0: begin
          if (accept_s) begin
            hdr0_r  <= in_flit.data;
            last0_r <= in_flit.last;
            if (in_flit.last) begin
              route_reg_r <= 1'b0;
              state_r     <= SHORT_EXIT;
            end else begin
              state_r <= HDR1;
            end
          end
        end
        HDR1: begin
          if (accept_s) begin
            hdr1_r  <= in_flit.data;
            last1_r <= in_flit.last;
            if (in_flit.last) begin
              route_reg_r <= 1'b0;
              state_r     <= SHORT_EXIT;
            end else begin
              state_r <= HDR2;
            end
          end
        end
        HDR2: begin
          if (accept_s) begin
            hdr2_r      <= in_flit.data;
            last2_r     <= in_flit.last;
            route_reg_r <= (in_flit.data[15:14] == 2'b00);
            if (in_flit.data[15:14] == 2'b00) begin
              state_r <= REPLAY0;
            end else begin
`ifdef OSD_REGACCESS_DEMUX_BYPASS_EN
              state_r <= REPLAY0;
`else
              state_r <= in_flit.last ? HDR0 : DROP;
`endif
            end
          end
        end
        REPLAY0: if (sel_ready_s) state_r <= last0_r ? HDR0 : REPLAY1;
        REPLAY1: if (sel_ready_s) state_r <= last1_r ? HDR0 : REPLAY2;
        REPLAY2: if (sel_ready_s) state_r <= last2_r ? HDR0 : STREAM;
        STREAM:  if (in_flit.valid && sel_ready_s && in_flit.last) state_r <= HDR0;
        DROP:    if (in_flit.valid && in_flit.last) state_r <= HDR0;
        default: state_r <= HDR0;
      endcase
    end
  end

endmodule
